// File: rtl/iadder_pkg.sv
// Shared types for the pipelined immediate adder / AGU: operation modes, access
// sizes and the occupancy states of the output skid buffer.
package iadder_pkg;

  typedef enum logic [1:0] {
    MODE_PC   = 2'b00,
    MODE_RS1  = 2'b01,
    MODE_JALR = 2'b10,
    MODE_LINK = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

endpackage

// File: rtl/iadder_core.sv
// Combinational address datapath: operand/addend select, (XLEN+1)-bit add,
// JALR bit-0 clear and alignment check.
module iadder_core
  import iadder_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IALIGN   = 4,
  parameter int LINK_INC = 4
) (
  input  logic [1:0]      mode_i,
  input  logic [1:0]      size_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] addr_o,
  output logic            misalign_o,
  output logic            carry_o
);

  localparam logic [XLEN-1:0] IMASK = XLEN'(IALIGN - 1);

  mode_e           mode;
  size_e           size;
  logic [XLEN-1:0] op, addend, mask;
  logic [XLEN:0]   sum;

  assign mode = mode_e'(mode_i);
  assign size = size_e'(size_i);

  always_comb begin
    op     = (mode == MODE_PC || mode == MODE_LINK) ? pc_i : rs1_i;
    addend = (mode == MODE_LINK) ? XLEN'(LINK_INC) : imm_i;
    sum    = {1'b0, op} + {1'b0, addend};
    carry_o = sum[XLEN];
    addr_o  = sum[XLEN-1:0];
    // JALR clears bit 0 after the add; carry still reflects the raw sum
    if (mode == MODE_JALR) addr_o[0] = 1'b0;

    mask = IMASK;
    if (mode == MODE_RS1) begin
      case (size)
        SIZE_B:  mask = XLEN'(0);
        SIZE_H:  mask = XLEN'(1);
        SIZE_W:  mask = XLEN'(3);
        default: mask = XLEN'(7);
      endcase
    end
    misalign_o = |(addr_o & mask);
    // doubleword accesses do not exist on a 32-bit datapath
    if (mode == MODE_RS1 && size == SIZE_D && XLEN == 32) misalign_o = 1'b1;
  end

endmodule

// File: rtl/iadder_agu_pipe.sv
// Pipelined AGU: iadder_core result registered behind a two-entry skid buffer
// (main register drives outputs, skid register absorbs one stall).
module iadder_agu_pipe
  import iadder_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IALIGN   = 4,
  parameter int LINK_INC = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [1:0]       mode_in,
  input  logic [1:0]       size_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [XLEN-1:0]  addr_out,
  output logic             misalign_out,
  output logic             carry_out,
  output logic [TAG_W-1:0] tag_out
);

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic             misalign;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } result_t;

  occ_e    occ_q, occ_d;
  result_t main_q, main_d, skid_q, skid_d, new_res;
  logic    accept, drain;

  iadder_core #(.XLEN(XLEN), .IALIGN(IALIGN), .LINK_INC(LINK_INC)) u_core (
    .mode_i     (mode_in),
    .size_i     (size_in),
    .pc_i       (pc_in),
    .rs1_i      (rs1_in),
    .imm_i      (imm_in),
    .addr_o     (new_res.addr),
    .misalign_o (new_res.misalign),
    .carry_o    (new_res.carry)
  );
  assign new_res.tag = tag_in;

  // ready depends only on registered occupancy, never on out_ready_in
  assign in_ready_out  = (occ_q != OCC_TWO);
  assign out_valid_out = (occ_q != OCC_EMPTY);
  assign accept        = in_valid_in & in_ready_out;
  assign drain         = out_valid_out & out_ready_in;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_in) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (accept) begin
          occ_d  = OCC_ONE;
          main_d = new_res;
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            occ_d  = OCC_TWO;
            skid_d = new_res;
          end else if (drain && !accept) begin
            occ_d = OCC_EMPTY;
          end else if (accept && drain) begin
            main_d = new_res;
          end
        end
        OCC_TWO: if (drain) begin
          occ_d  = OCC_ONE;
          main_d = skid_q;
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign addr_out     = main_q.addr;
  assign misalign_out = main_q.misalign;
  assign carry_out    = main_q.carry;
  assign tag_out      = main_q.tag;

endmodule

// File: tb/tb_iadder_agu_pipe.sv
// Bench for iadder_agu_pipe: IALIGN=4 and IALIGN=2 instances driven in lockstep,
// checked against a 2-deep FIFO model with arithmetic address rules.
module tb_iadder_agu_pipe;
  import iadder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  mode, size;
  logic [31:0] pc, rs1, imm;
  logic [4:0]  tag;

  logic        rdy_a, vld_a, mis_a, cy_a, rdy_b, vld_b, mis_b, cy_b;
  logic [31:0] addr_a, addr_b;
  logic [4:0]  tag_a, tag_b;

  always #5 clk = ~clk;

  iadder_agu_pipe #(.XLEN(32), .IALIGN(4), .LINK_INC(4), .TAG_W(5)) dut_a (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .in_valid_in(in_valid), .in_ready_out(rdy_a),
    .mode_in(mode), .size_in(size), .pc_in(pc), .rs1_in(rs1), .imm_in(imm), .tag_in(tag),
    .out_valid_out(vld_a), .out_ready_in(out_ready),
    .addr_out(addr_a), .misalign_out(mis_a), .carry_out(cy_a), .tag_out(tag_a)
  );

  iadder_agu_pipe #(.XLEN(32), .IALIGN(2), .LINK_INC(4), .TAG_W(5)) dut_b (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .in_valid_in(in_valid), .in_ready_out(rdy_b),
    .mode_in(mode), .size_in(size), .pc_in(pc), .rs1_in(rs1), .imm_in(imm), .tag_in(tag),
    .out_valid_out(vld_b), .out_ready_in(out_ready),
    .addr_out(addr_b), .misalign_out(mis_b), .carry_out(cy_b), .tag_out(tag_b)
  );

  typedef struct {
    logic [31:0] addr;
    bit          mis4;
    bit          mis2;
    bit          cy;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  function automatic exp_t ref_calc(input logic [1:0] m, input logic [1:0] s,
                                    input logic [31:0] p, input logic [31:0] r,
                                    input logic [31:0] i, input logic [4:0] t);
    exp_t e;
    longint unsigned op, ad, sum;
    op     = (m == 2'd0 || m == 2'd3) ? longint'(p) : longint'(r);
    ad     = (m == 2'd3) ? 64'd4 : longint'(i);
    sum    = op + ad;
    e.cy   = (sum >= 64'h1_0000_0000);
    e.addr = 32'(sum % 64'h1_0000_0000);
    if (m == 2'd2) e.addr = e.addr & 32'hFFFF_FFFE;
    if (m == 2'd1) begin
      e.mis4 = (s == 2'd3) ? 1'b1 : ((e.addr % (32'd1 << s)) != 0);
      e.mis2 = e.mis4;
    end else begin
      e.mis4 = (e.addr % 4) != 0;
      e.mis2 = (e.addr % 2) != 0;
    end
    e.tag = t;
    return e;
  endfunction

  // One clock: advance the FIFO model from the inputs, then compare both DUTs.
  task automatic cyc();
    int   occ;
    bit   acc, dr;
    exp_t e;
    occ = q.size();
    acc = in_valid && occ < 2;
    dr  = occ > 0 && out_ready;
    e   = ref_calc(mode, size, pc, rs1, imm, tag);
    @(posedge clk);
    #2;
    if (flush) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    chk("valid", vld_a, q.size() != 0);
    chk("ready", rdy_a, q.size() < 2);
    chk("valid_b", vld_b, q.size() != 0);
    chk("ready_b", rdy_b, q.size() < 2);
    if (q.size() != 0) begin
      chk("addr", addr_a, q[0].addr);
      chk("mis", mis_a, q[0].mis4);
      chk("carry", cy_a, q[0].cy);
      chk("tag", tag_a, q[0].tag);
      chk("addr_b", addr_b, q[0].addr);
      chk("mis_b", mis_b, q[0].mis2);
    end
  endtask

  task automatic req(input logic [1:0] m, input logic [1:0] s, input logic [31:0] p,
                     input logic [31:0] r, input logic [31:0] i, input logic [4:0] t);
    in_valid = 1'b1; mode = m; size = s; pc = p; rs1 = r; imm = i; tag = t;
  endtask

  task automatic idle();
    in_valid = 1'b0; mode = 'x; size = 'x; pc = 'x; rs1 = 'x; imm = 'x; tag = 'x;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #12;
    chk("rst_vld", vld_a, 0);
    chk("rst_rdy", rdy_a, 1);
    chk("rst_addr", addr_a, 0);
    chk("rst_mis", mis_a, 0);
    chk("rst_carry", cy_a, 0);
    chk("rst_tag", tag_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // mode examples, one result in flight at a time
    out_ready = 1'b1;
    req(2'd0, 2'd0, 32'h1000, 32'h0, 32'hFFFF_FFF8, 5'd1); cyc();
    chk("pc_addr", addr_a, 32'h0000_0FF8);
    chk("pc_carry", cy_a, 1);
    chk("pc_mis", mis_a, 0);
    req(2'd3, 2'd0, 32'h1000, 32'h0, 32'h55, 5'd2); cyc();
    chk("link_addr", addr_a, 32'h1004);
    req(2'd2, 2'd0, 32'h0, 32'h2001, 32'h4, 5'd3); cyc();
    chk("jalr_addr", addr_a, 32'h2004);
    chk("jalr_mis", mis_a, 0);
    req(2'd1, 2'd2, 32'h0, 32'h100, 32'h2, 5'd4); cyc();
    chk("ldw_mis", mis_a, 1);
    req(2'd1, 2'd1, 32'h0, 32'h100, 32'h2, 5'd5); cyc();
    chk("ldh_mis", mis_a, 0);
    req(2'd1, 2'd3, 32'h0, 32'h100, 32'h2, 5'd6); cyc();
    chk("ldd_mis", mis_a, 1);
    req(2'd0, 2'd0, 32'h1000, 32'h0, 32'h2, 5'd7); cyc();
    chk("ia4_mis", mis_a, 1);
    chk("ia2_mis", mis_b, 0);
    idle(); cyc();

    // backpressure: third request must be refused
    out_ready = 1'b0;
    req(2'd0, 2'd0, 32'h3000, 32'h0, 32'h10, 5'd10); cyc();
    chk("bp_rdy1", rdy_a, 1);
    req(2'd0, 2'd0, 32'h3000, 32'h0, 32'h20, 5'd11); cyc();
    chk("bp_rdy2", rdy_a, 0);
    req(2'd0, 2'd0, 32'h3000, 32'h0, 32'h30, 5'd12); cyc();
    chk("bp_rdy3", rdy_a, 0);
    chk("bp_hold", addr_a, 32'h3010);
    idle(); out_ready = 1'b1; cyc();
    chk("bp_second", tag_a, 11);
    cyc();
    chk("bp_empty", vld_a, 0);

    // flush with buffer full and a same-cycle request
    out_ready = 1'b0;
    req(2'd1, 2'd0, 32'h0, 32'h500, 32'h1, 5'd13); cyc();
    req(2'd1, 2'd0, 32'h0, 32'h600, 32'h1, 5'd14); cyc();
    req(2'd1, 2'd0, 32'h0, 32'h700, 32'h1, 5'd20); flush = 1'b1; cyc();
    chk("fl_vld", vld_a, 0);
    chk("fl_rdy", rdy_a, 1);
    flush = 1'b0; idle(); out_ready = 1'b1; cyc(); cyc();

    // reset while two results are held
    out_ready = 1'b0;
    req(2'd0, 2'd0, 32'h4000, 32'h0, 32'h8, 5'd21); cyc();
    req(2'd0, 2'd0, 32'h4000, 32'h0, 32'hC, 5'd22); cyc();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("mrst_vld", vld_a, 0);
    chk("mrst_rdy", rdy_a, 1);
    chk("mrst_addr", addr_a, 0);
    chk("mrst_vld_b", vld_b, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) != 0) begin
        req(2'($urandom), 2'($urandom), $urandom & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)),
            $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom,
            5'($urandom));
      end else begin
        idle();
      end
      cyc();
    end
    flush = 1'b0; idle(); out_ready = 1'b1; cyc(); cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
